// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the single-port memory arbiter between
// the mips fetch and data requesters.
package mem_arb_pkg;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } owner_t;

    typedef struct packed {
        logic   valid;
        owner_t owner;
    } tag_t;

    // Values of the memory rd_wr and access_size inputs
    localparam logic       RD_WORD = 1'b1;
    localparam logic       WR      = 1'b0;
    localparam logic [1:0] SZ_WORD = 2'd0;

    localparam tag_t TAG_IDLE = '{valid: 1'b0, owner: OWN_I};

endpackage

// File: rtl/arb_tag_pipe.sv
// Fixed-depth shift register of read tags that tracks which requester owns
// the word emerging from memory DEPTH cycles after a grant.
module arb_tag_pipe
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic clk,
    input  logic reset,
    input  tag_t load_tag,
    output tag_t last_tag
);

    tag_t stages [DEPTH];

    // Clearing every stage is what drops in-flight reads on reset
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < DEPTH; k++) begin
                stages[k] <= TAG_IDLE;
            end
        end else begin
            stages[0] <= load_tag;
            for (int k = 1; k < DEPTH; k++) begin
                stages[k] <= stages[k-1];
            end
        end
    end

    assign last_tag = stages[DEPTH-1];

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between instruction fetch and data access:
// data has priority, an aging counter keeps fetch from starving.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int RD_LATENCY   = 1,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_req,
    input  logic [31:0]      i_addr,
    output logic             i_gnt,
    output logic             i_rvalid,
    output logic [31:0]      i_rdata,
    input  logic             d_req,
    input  logic [31:0]      d_addr,
    input  logic             d_rd_wr,
    input  logic [1:0]       d_size,
    input  logic [31:0]      d_wdata,
    output logic             d_gnt,
    output logic             d_rvalid,
    output logic [31:0]      d_rdata,
    output logic [31:0]      m_addr,
    output logic [31:0]      m_data_in,
    input  logic [31:0]      m_data_out,
    output logic [1:0]       m_access_size,
    output logic             m_rd_wr,
    output logic             m_enable,
    output logic [CNT_W-1:0] conflict_cnt
);

    localparam logic [3:0]       LIMIT   = 4'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [3:0] wait_cnt;
    logic       fetch_forced;
    tag_t       load_tag;
    tag_t       last_tag;

    assign fetch_forced = (wait_cnt == LIMIT);

    // Gating with reset keeps grants and the memory strobe quiet while in reset
    assign i_gnt = reset & i_req & (~d_req | fetch_forced);
    assign d_gnt = reset & d_req & ~i_gnt;

    always_comb begin
        m_enable      = i_gnt | d_gnt;
        m_rd_wr       = RD_WORD;
        m_addr        = '0;
        m_data_in     = '0;
        m_access_size = SZ_WORD;
        if (d_gnt) begin
            m_rd_wr       = d_rd_wr;
            m_addr        = d_addr;
            m_data_in     = d_wdata;
            m_access_size = d_size;
        end else if (i_gnt) begin
            m_addr = i_addr;
        end
    end

    always_comb begin
        load_tag       = TAG_IDLE;
        load_tag.valid = i_gnt | (d_gnt & (d_rd_wr != WR));
        load_tag.owner = d_gnt ? OWN_D : OWN_I;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wait_cnt     <= 4'd0;
            conflict_cnt <= '0;
        end else begin
            if (!i_req || i_gnt) begin
                wait_cnt <= 4'd0;
            end else if (wait_cnt != LIMIT) begin
                wait_cnt <= wait_cnt + 4'd1;
            end
            if (i_req && d_req) begin
                conflict_cnt <= conflict_cnt + CNT_ONE;
            end
        end
    end

    arb_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk      (clk),
        .reset    (reset),
        .load_tag (load_tag),
        .last_tag (last_tag)
    );

    assign i_rvalid = last_tag.valid && (last_tag.owner == OWN_I);
    assign d_rvalid = last_tag.valid && (last_tag.owner == OWN_D);
    assign i_rdata  = m_data_out;
    assign d_rdata  = m_data_out;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter driving a behavioural single-port
// memory with the same read latency as the arbiter is configured for.
module tb_mem_port_arbiter;

    localparam int RD_LATENCY   = 3;
    localparam int STARVE_LIMIT = 4;
    localparam int CNT_W        = 32;
    localparam logic [31:0] BASE = 32'h8002_0000;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_req;
    logic [31:0]      i_addr;
    logic             i_gnt;
    logic             i_rvalid;
    logic [31:0]      i_rdata;
    logic             d_req;
    logic [31:0]      d_addr;
    logic             d_rd_wr;
    logic [1:0]       d_size;
    logic [31:0]      d_wdata;
    logic             d_gnt;
    logic             d_rvalid;
    logic [31:0]      d_rdata;
    logic [31:0]      m_addr;
    logic [31:0]      m_data_in;
    logic [31:0]      m_data_out;
    logic [1:0]       m_access_size;
    logic             m_rd_wr;
    logic             m_enable;
    logic [CNT_W-1:0] conflict_cnt;

    typedef struct {
        logic        owner;
        logic [31:0] data;
        int          due;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] ref_mem [256];
    logic [31:0] mem [256];
    logic [31:0] rd_pipe [RD_LATENCY];
    bit          loaded = 1'b0;
    int          cyc = 0;
    int          check_count = 0;
    int          err_count = 0;
    int          model_wait = 0;
    int          model_conflicts = 0;

    mem_port_arbiter #(
        .RD_LATENCY   (RD_LATENCY),
        .STARVE_LIMIT (STARVE_LIMIT),
        .CNT_W        (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_req         (i_req),
        .i_addr        (i_addr),
        .i_gnt         (i_gnt),
        .i_rvalid      (i_rvalid),
        .i_rdata       (i_rdata),
        .d_req         (d_req),
        .d_addr        (d_addr),
        .d_rd_wr       (d_rd_wr),
        .d_size        (d_size),
        .d_wdata       (d_wdata),
        .d_gnt         (d_gnt),
        .d_rvalid      (d_rvalid),
        .d_rdata       (d_rdata),
        .m_addr        (m_addr),
        .m_data_in     (m_data_in),
        .m_data_out    (m_data_out),
        .m_access_size (m_access_size),
        .m_rd_wr       (m_rd_wr),
        .m_enable      (m_enable),
        .conflict_cnt  (conflict_cnt)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int i);
        return {8'h5A, i[7:0], ~i[7:0], 8'h3C};
    endfunction

    // Behavioural memory: word writes on the grant edge, reads appear RD_LATENCY edges later
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (!loaded) begin
            for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
            loaded <= 1'b1;
        end else if (m_enable && !m_rd_wr) begin
            mem[m_addr[9:2]] <= m_data_in;
        end
        rd_pipe[0] <= mem[m_addr[9:2]];
        for (int i = 1; i < RD_LATENCY; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign m_data_out = rd_pipe[RD_LATENCY-1];

    task automatic check_output(input string tag, input logic [63:0] actual,
                                input logic [63:0] expected);
        check_count++;
        if (actual !== expected) begin
            err_count++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at cycle %0d",
                     tag, actual, expected, cyc);
        end
    endtask

    // Response monitor: pops the scoreboard whenever an rvalid appears
    always @(negedge clk) begin
        exp_t front;
        if (sb_q.size() > 0 && sb_q[0].due < cyc) begin
            front = sb_q.pop_front();
            check_output("rv_missing", 64'(front.due), 64'(cyc));
        end
        if (i_rvalid || d_rvalid) begin
            check_output("rv_excl", 64'(i_rvalid && d_rvalid), 64'd0);
            if (sb_q.size() == 0) begin
                check_output("rv_unexpected", {62'd0, i_rvalid, d_rvalid}, 64'd0);
            end else begin
                front = sb_q.pop_front();
                check_output("rv_owner", {62'd0, i_rvalid, d_rvalid},
                             {62'd0, ~front.owner, front.owner});
                check_output("rv_due", 64'(cyc), 64'(front.due));
                check_output("rv_data", front.owner ? d_rdata : i_rdata, front.data);
            end
        end
    end

    task automatic apply_stimulus(input logic ireq, input logic [31:0] iaddr,
                                  input logic dreq, input logic [31:0] daddr,
                                  input logic drw, input logic [1:0] dsize,
                                  input logic [31:0] dwdata);
        logic exp_i;
        logic exp_d;
        exp_t e;
        @(negedge clk);
        i_req   = ireq;
        i_addr  = iaddr;
        d_req   = dreq;
        d_addr  = daddr;
        d_rd_wr = drw;
        d_size  = dsize;
        d_wdata = dwdata;
        #1;
        exp_i = ireq && (!dreq || model_wait == STARVE_LIMIT);
        exp_d = dreq && !exp_i;
        check_output("conflict_cnt", 64'(conflict_cnt), 64'(model_conflicts));
        check_output("i_gnt", 64'(i_gnt), 64'(exp_i));
        check_output("d_gnt", 64'(d_gnt), 64'(exp_d));
        check_output("m_enable", 64'(m_enable), 64'(exp_i || exp_d));
        check_output("m_rd_wr", 64'(m_rd_wr), exp_d ? 64'(drw) : 64'd1);
        check_output("m_addr", 64'(m_addr), exp_d ? 64'(daddr) : exp_i ? 64'(iaddr) : 64'd0);
        check_output("m_data_in", 64'(m_data_in), exp_d ? 64'(dwdata) : 64'd0);
        check_output("m_size", 64'(m_access_size), exp_d ? 64'(dsize) : 64'd0);
        if (exp_i) begin
            e.owner = 1'b0; e.data = ref_mem[iaddr[9:2]]; e.due = cyc + RD_LATENCY;
            sb_q.push_back(e);
        end
        if (exp_d && drw) begin
            e.owner = 1'b1; e.data = ref_mem[daddr[9:2]]; e.due = cyc + RD_LATENCY;
            sb_q.push_back(e);
        end
        if (exp_d && !drw) ref_mem[daddr[9:2]] = dwdata;
        if (ireq && !exp_i)
            model_wait = (model_wait == STARVE_LIMIT) ? model_wait : model_wait + 1;
        else
            model_wait = 0;
        if (ireq && dreq) model_conflicts++;
    endtask

    task automatic idle_cycles(input int n);
        for (int k = 0; k < n; k++) apply_stimulus(1'b0, '0, 1'b0, '0, 1'b1, 2'd0, '0);
    endtask

    initial begin
        int mism;
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);

        // Reset with both requests high: nothing may be granted or counted
        reset = 1'b0; i_req = 1'b1; i_addr = BASE; d_req = 1'b1; d_addr = BASE + 32'h40;
        d_rd_wr = 1'b0; d_size = 2'd1; d_wdata = 32'h1234_5678;
        #2;
        check_output("rst_i_gnt", 64'(i_gnt), 64'd0);
        check_output("rst_d_gnt", 64'(d_gnt), 64'd0);
        check_output("rst_m_enable", 64'(m_enable), 64'd0);
        check_output("rst_m_rd_wr", 64'(m_rd_wr), 64'd1);
        check_output("rst_m_addr", 64'(m_addr), 64'd0);
        check_output("rst_m_data_in", 64'(m_data_in), 64'd0);
        check_output("rst_m_size", 64'(m_access_size), 64'd0);
        check_output("rst_rvalid", {62'd0, i_rvalid, d_rvalid}, 64'd0);
        @(negedge clk);
        check_output("rst_conflict", 64'(conflict_cnt), 64'd0);
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0;

        // Fetch only, three consecutive words
        for (int k = 0; k < 3; k++)
            apply_stimulus(1'b1, BASE + 32'(4 * k), 1'b0, '0, 1'b1, 2'd0, '0);
        idle_cycles(RD_LATENCY + 1);

        // Data write then read back of the same word
        apply_stimulus(1'b0, '0, 1'b1, BASE + 32'h100, 1'b0, 2'd0, 32'hDEAD_BEEF);
        apply_stimulus(1'b0, '0, 1'b1, BASE + 32'h100, 1'b1, 2'd0, '0);
        idle_cycles(RD_LATENCY + 1);

        // Sustained contention: expect d,d,d,d,i repeating
        for (int k = 0; k < 10; k++)
            apply_stimulus(1'b1, BASE + 32'(4 * k), 1'b1, BASE + 32'h80 + 32'(4 * k),
                           1'b1, 2'd2, '0);
        idle_cycles(RD_LATENCY + 1);
        check_output("conflict_after_10", 64'(conflict_cnt), 64'd10);

        // Interleaved owners back-to-back
        apply_stimulus(1'b1, BASE + 32'h10, 1'b0, '0, 1'b1, 2'd0, '0);
        apply_stimulus(1'b0, '0, 1'b1, BASE + 32'h100, 1'b1, 2'd0, '0);
        apply_stimulus(1'b1, BASE + 32'h14, 1'b0, '0, 1'b1, 2'd0, '0);

        // Random mix of fetches, reads and writes in a small window
        for (int k = 0; k < 80; k++) begin
            logic rw;
            rw = 1'($urandom_range(0, 2) != 0);
            apply_stimulus(1'($urandom_range(0, 1)), BASE + 32'({$urandom_range(0, 15), 2'b00}),
                           1'($urandom_range(0, 1)), BASE + 32'({$urandom_range(0, 15), 2'b00}),
                           rw, rw ? 2'($urandom_range(0, 2)) : 2'd0, $urandom);
        end
        idle_cycles(RD_LATENCY + 2);
        check_output("sb_empty", 64'(sb_q.size()), 64'd0);

        // Reset one cycle after a data read grant: its response must vanish
        apply_stimulus(1'b0, '0, 1'b1, BASE + 32'h20, 1'b1, 2'd0, '0);
        @(negedge clk);
        reset = 1'b0; sb_q.delete(); model_wait = 0; model_conflicts = 0;
        i_req = 1'b1; d_req = 1'b0;
        #1;
        check_output("midrst_i_gnt", 64'(i_gnt), 64'd0);
        check_output("midrst_m_enable", 64'(m_enable), 64'd0);
        check_output("midrst_conflict", 64'(conflict_cnt), 64'd0);
        @(negedge clk);
        reset = 1'b1; i_req = 1'b0;

        // Idle: no requests, no writes, no responses
        idle_cycles(20);
        check_output("sb_empty_end", 64'(sb_q.size()), 64'd0);
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        check_output("mem_image", 64'(mism), 64'd0);

        $display("Result: errors=%0d of %0d checks", err_count, check_count);
        $finish;
    end

endmodule
